jpeg_dezigzag_buffer: RTL and testbench



---
 rtl/jpeg_dezigzag_pkg.sv | 36 +++
 rtl/jpeg_dezigzag_bank.sv | 24 ++
 rtl/jpeg_dezigzag_buffer.sv | 101 ++++++++++
 tb/tb_jpeg_dezigzag_buffer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_dezigzag_pkg.sv
// Shared constants for the zigzag-to-raster reorder buffer: block size, scan table and
// the per-bank lifecycle enum used by the top-level checks.
package jpeg_dezigzag_pkg;

  localparam int unsigned COEF_PER_BLK = 64;

  // Zigzag scan position -> raster (row*8+col) position.
  localparam logic [5:0] ZZ2RASTER [COEF_PER_BLK] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {
    BankEmpty,
    BankFilling,
    BankFull,
    BankDraining
  } bank_state_e;

  function automatic bank_state_e bank_state(input logic       full,
                                             input logic       is_wr,
                                             input logic       is_rd,
                                             input logic [5:0] rcnt);
    if (full && is_rd && (rcnt != 6'd0)) return BankDraining;
    else if (full)                       return BankFull;
    else if (is_wr)                      return BankFilling;
    else                                 return BankEmpty;
  endfunction

endpackage

// File: rtl/jpeg_dezigzag_bank.sv
// One 64-entry coefficient bank: synchronous write port, combinational read port.
module jpeg_dezigzag_bank
  import jpeg_dezigzag_pkg::*;
#(
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [5:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [5:0]        raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [COEF_PER_BLK];

  // Storage is deliberately not reset; readers qualify it with the bank-full flag.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jpeg_dezigzag_buffer.sv
// Ping-pong 8x8 block buffer: accepts coefficients in zigzag order, emits them in raster
// order. Writes scatter through the scan table; reads walk the bank linearly.
module jpeg_dezigzag_buffer
  import jpeg_dezigzag_pkg::*;
#(
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_index,
  output logic              out_last
);

  logic [1:0]        bank_full_q, bank_full_d;
  logic              wb_q, wb_d;
  logic              rb_q, rb_d;
  logic [5:0]        wcnt_q, wcnt_d;
  logic [5:0]        rcnt_q, rcnt_d;
  logic              wr_fire, rd_fire;
  logic [DATA_W-1:0] rdata [2];
  bank_state_e       bank_st [2];

  assign in_ready  = !bank_full_q[wb_q];
  assign out_valid = bank_full_q[rb_q];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  assign out_index = rcnt_q;
  assign out_last  = (rcnt_q == 6'd63);
  assign out_data  = rb_q ? rdata[1] : rdata[0];

  // A write and a read can never target the same bank in one cycle (one needs it empty,
  // the other full), so both flag updates below apply independently.
  always_comb begin
    bank_full_d = bank_full_q;
    wb_d        = wb_q;
    rb_d        = rb_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    if (wr_fire) begin
      wcnt_d = wcnt_q + 6'd1;
      if (wcnt_q == 6'd63) begin
        bank_full_d[wb_q] = 1'b1;
        wb_d              = !wb_q;
      end
    end
    if (rd_fire) begin
      rcnt_d = rcnt_q + 6'd1;
      if (rcnt_q == 6'd63) begin
        bank_full_d[rb_q] = 1'b0;
        rb_d              = !rb_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full_q <= 2'b00;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      wcnt_q      <= 6'd0;
      rcnt_q      <= 6'd0;
    end else begin
      bank_full_q <= bank_full_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    jpeg_dezigzag_bank #(
      .DATA_W (DATA_W)
    ) u_bank (
      .clk   (clk),
      .we    (wr_fire && (wb_q == 1'(g))),
      .waddr (ZZ2RASTER[wcnt_q]),
      .wdata (in_data),
      .raddr (rcnt_q),
      .rdata (rdata[g])
    );

    assign bank_st[g] = bank_state(bank_full_q[g], wb_q == 1'(g), rb_q == 1'(g), rcnt_q);

    a_empty_next: assert property (@(posedge clk) disable iff (!rst_n)
      (bank_st[g] == BankEmpty) |=> (bank_st[g] inside {BankEmpty, BankFilling}));
    a_full_next: assert property (@(posedge clk) disable iff (!rst_n)
      (bank_st[g] == BankFull) |=> (bank_st[g] inside {BankFull, BankDraining}));
  end

  a_both_full_stall: assert property (@(posedge clk) disable iff (!rst_n)
    (bank_full_q == 2'b11) |-> !in_ready);

endmodule

// File: tb/tb_jpeg_dezigzag_buffer.sv
// Randomised scoreboard bench for jpeg_dezigzag_buffer; the reference scan order is built
// by walking the anti-diagonals of an 8x8 block.
module tb_jpeg_dezigzag_buffer;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [5:0]    out_index;
  logic          out_last;

  jpeg_dezigzag_buffer #(
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [5:0]    idx;
    logic          last;
  } beat_t;

  int            total = 0;
  int            bad = 0;
  beat_t         exp_q[$];
  logic [DW-1:0] blk[64];
  int            zz[64];
  int            rz[64];
  int            wcount = 0;
  int            cyc = 0;
  int            last_full_cyc = -10;
  logic          prev_ov = 1'b0;
  int            out_pct = 0;
  int            out_cnt = 0;
  int            first_out_cyc = 0;
  int            last_out_cyc = 0;
  logic [DW-1:0] got[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference scan: even diagonals run bottom-left to top-right, odd ones the other way.
  initial begin
    int n;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 8) ? s : 7;
      if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zz[n] = r * 8 + (s - r); n++; end
      else            for (int r = lo; r <= hi; r++) begin zz[n] = r * 8 + (s - r); n++; end
    end
    for (int k = 0; k < 64; k++) rz[zz[k]] = k;
  end

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    out_ready = ($urandom_range(99) < out_pct);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) check("latency", cyc, last_full_cyc + 1);
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_index", out_index, e.idx);
          check("out_last", out_last, e.last);
        end
        got[out_index] = out_data;
        if (out_cnt == 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        blk[wcount] = in_data;
        wcount++;
        if (wcount == 64) begin
          for (int r = 0; r < 64; r++) begin
            beat_t e;
            e.data = blk[rz[r]];
            e.idx  = 6'(r);
            e.last = (r == 63);
            exp_q.push_back(e);
          end
          wcount = 0;
          last_full_cyc = cyc;
        end
      end
    end
  end

  task automatic send(input int n, input int vpct, input bit seq, output int stalls);
    int k, budget;
    k = 0;
    budget = 0;
    stalls = 0;
    while (k < n && budget < 20000) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(99) < vpct);
      in_data  = seq ? DW'(k) : DW'($urandom);
      @(negedge clk);
      if (in_valid && !in_ready) stalls++;
      if (in_valid && in_ready) k++;
      budget++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (k < n) check("send_timeout", k, n);
  endtask

  task automatic drain(input int budget);
    int b;
    b = 0;
    while ((exp_q.size() != 0 || out_valid) && b < budget) begin
      @(negedge clk);
      b++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 0);
    exp_q.delete();
    wcount = 0;
    prev_ov = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int st, b;
    #12;
    check("init_in_ready", in_ready, 1);
    check("init_out_valid", out_valid, 0);
    check("init_out_index", out_index, 0);
    check("init_out_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single block with data equal to zigzag index.
    out_pct = 100;
    out_cnt = 0;
    send(64, 100, 1'b1, st);
    drain(200);
    check("single_count", out_cnt, 64);
    check("spot_r1", got[1], 1);
    check("spot_r2", got[2], 5);
    check("spot_r8", got[8], 2);
    check("spot_r9", got[9], 4);
    check("spot_r16", got[16], 3);
    check("spot_r63", got[63], 63);

    // Back-to-back blocks: block N+1 completes on the same edge block N finishes draining.
    out_cnt = 0;
    send(256, 100, 1'b1, st);
    check("b2b_stalls", st, 0);
    drain(300);
    check("b2b_count", out_cnt, 256);
    check("b2b_no_gaps", last_out_cyc - first_out_cyc, 255);

    // Backpressure: both banks fill, then release.
    out_pct = 0;
    repeat (2) @(posedge clk);
    out_cnt = 0;
    send(128, 100, 1'b1, st);
    check("bp_stalls", st, 0);
    @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_index", out_index, 0);
    check("bp_out_data", out_data, 0);
    repeat (5) @(negedge clk);
    check("bp_hold_index", out_index, 0);
    check("bp_hold_data", out_data, 0);
    out_pct = 100;
    b = 0;
    do begin
      @(negedge clk); #1;
      b++;
    end while (!in_ready && b < 300);
    check("bp_in_ready_back", in_ready, 1);
    // Block 0 fully drained plus block 1's first beat on this same cycle.
    check("bp_drained_beats", out_cnt, 65);
    check("bp_next_block_data", out_data, 64);
    drain(300);

    // Random stalls on both sides over 20 blocks.
    out_pct = 50;
    send(20 * 64, 50, 1'b0, st);
    drain(5000);

    // Reset in the middle of a write.
    out_pct = 100;
    send(30, 100, 1'b1, st);
    do_reset();
    out_cnt = 0;
    send(64, 100, 1'b1, st);
    drain(300);
    check("rst_write_count", out_cnt, 64);

    // Reset in the middle of a drain.
    out_cnt = 0;
    send(64, 100, 1'b1, st);
    b = 0;
    while (out_cnt < 10 && b < 300) begin
      @(negedge clk);
      b++;
    end
    check("mid_drain_reached", out_cnt >= 10, 1);
    do_reset();
    out_cnt = 0;
    send(64, 100, 1'b1, st);
    drain(300);
    check("rst_drain_count", out_cnt, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
